// File: rtl/sr_alu_arb.sv
// sr_alu_arb: two-port arbiter and sequencer sharing one combinational sr_alu.
// One operation at a time: IDLE (arbitrate/accept) -> EXEC (drive ALU) -> RESP (hold result).
// Build option: define SR_ALU_ARB_RR_EN for round-robin arbitration between the ports;
// when it is undefined, port 0 has fixed priority and no pointer register is built.

`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif

module sr_alu_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_srcA,
  input  logic [31:0] req0_srcB,
  input  logic [2:0]  req0_oper,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_srcA,
  input  logic [31:0] req1_srcB,
  input  logic [2:0]  req1_oper,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  output logic [2:0]  alu_oper,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q;
  logic        grant_q;
  logic        rsp0_valid_q, rsp1_valid_q;
  logic [31:0] result_q;
  logic        zero_q;
  // ALU drive registers double as the latched operands; they hold idle values outside EXEC.
  logic [31:0] alu_srca_q, alu_srcb_q;
  logic [2:0]  alu_oper_q;

  logic win;     // 1: port 1 wins arbitration this cycle
  logic idle;
  logic accept;

`ifdef SR_ALU_ARB_RR_EN
  logic last_q;  // port granted most recently

  // Round-robin: on contention grant the port not granted last; a lone requester always wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      win = ~last_q;
    end else begin
      win = req1_valid;
    end
  end
`else
  // Fixed priority: port 1 wins only when port 0 is not requesting.
  always_comb begin
    win = ~req0_valid;
  end
`endif

  assign idle       = (state_q == StIdle) && !rst;
  assign req0_ready = idle && req0_valid && !win;
  assign req1_ready = idle && req1_valid && win;
  assign accept     = req0_ready || req1_ready;

  // Sequencer: accept -> drive ALU for one cycle -> hold response until the owner takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      alu_srca_q   <= '0;
      alu_srcb_q   <= '0;
      alu_oper_q   <= `ALU_ADD;
`ifdef SR_ALU_ARB_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            alu_srca_q <= win ? req1_srcA : req0_srcA;
            alu_srcb_q <= win ? req1_srcB : req0_srcB;
            alu_oper_q <= win ? req1_oper : req0_oper;
            grant_q    <= win;
`ifdef SR_ALU_ARB_RR_EN
            last_q     <= win;
`endif
            state_q    <= StExec;
          end
        end
        StExec: begin
          result_q     <= alu_result;
          zero_q       <= alu_zero;
          rsp0_valid_q <= ~grant_q;
          rsp1_valid_q <= grant_q;
          alu_srca_q   <= '0;
          alu_srcb_q   <= '0;
          alu_oper_q   <= `ALU_ADD;
          state_q      <= StResp;
        end
        StResp: begin
          if (grant_q ? rsp1_ready : rsp0_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_srcA    = alu_srca_q;
  assign alu_srcB    = alu_srcb_q;
  assign alu_oper    = alu_oper_q;

  // Response data is forced to zero whenever the port's valid is low.
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_valid_q ? result_q : '0;
  assign rsp0_zero   = rsp0_valid_q & zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_valid_q ? result_q : '0;
  assign rsp1_zero   = rsp1_valid_q & zero_q;

endmodule

// File: tb/tb_sr_alu_arb.sv
// Testbench for sr_alu_arb: random and directed stimulus, reference model with scoreboard,
// and a stand-in combinational ALU on the shared ALU port.

`timescale 1ns/1ps

`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif
`ifndef ALU_OR
`define ALU_OR 3'b001
`endif
`ifndef ALU_SRL
`define ALU_SRL 3'b010
`endif
`ifndef ALU_SLTU
`define ALU_SLTU 3'b011
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'b100
`endif

module tb_sr_alu_arb;

`ifdef SR_ALU_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_srcA, req0_srcB, req1_srcA, req1_srcB;
  logic [2:0]  req0_oper, req1_oper;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [31:0] alu_srcA, alu_srcB, alu_result;
  logic [2:0]  alu_oper;
  logic        alu_zero;

  sr_alu_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_srcA  (req0_srcA),
    .req0_srcB  (req0_srcB),
    .req0_oper  (req0_oper),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_srcA  (req1_srcA),
    .req1_srcB  (req1_srcB),
    .req1_oper  (req1_oper),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_result(rsp0_result),
    .rsp0_zero  (rsp0_zero),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_result(rsp1_result),
    .rsp1_zero  (rsp1_zero),
    .alu_srcA   (alu_srcA),
    .alu_srcB   (alu_srcB),
    .alu_oper   (alu_oper),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      `ALU_ADD:  return a + b;
      `ALU_OR:   return a | b;
      `ALU_SRL:  return a >> b[4:0];
      `ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      `ALU_SUB:  return a - b;
      default:   return 32'd0;
    endcase
  endfunction

  // Stand-in for the shared sr_alu.
  assign alu_result = alu_f(alu_oper, alu_srcA, alu_srcB);
  assign alu_zero   = (alu_result == 32'd0);

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s cycle=%0d", name, cyc);
  endtask

  // ---------------- Reference model + scoreboard ----------------
  typedef struct {
    int          port;
    logic [31:0] res;
    logic        zero;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          outstanding = 0;   // operations accepted and not yet released
  int          idle_from   = 0;   // first cycle the block may accept again
  int          exec_cyc    = -10; // cycle in which the ALU must carry the accepted operands
  logic [31:0] ex_a, ex_b;
  logic [2:0]  ex_op;
  int          last_grant  = 1;

  // Decides who must be granted each cycle and predicts the response.
  always @(negedge clk) begin
    bit   idle;
    int   win;
    exp_t e;
    if (rst) begin
      sb.delete();
      outstanding = 0;
      idle_from   = cyc + 1;
      last_grant  = 1;
      chk("req0_ready_in_reset", 32'(req0_ready), 32'd0);
      chk("req1_ready_in_reset", 32'(req1_ready), 32'd0);
    end else begin
      idle = (outstanding == 0) && (cyc >= idle_from);
      win  = -1;
      if (idle) begin
        if (req0_valid && req1_valid) win = RrEn ? 1 - last_grant : 0;
        else if (req0_valid)          win = 0;
        else if (req1_valid)          win = 1;
      end
      chk("req0_ready", 32'(req0_ready), 32'(win == 0));
      chk("req1_ready", 32'(req1_ready), 32'(win == 1));
      if (win >= 0) begin
        ex_a  = (win == 1) ? req1_srcA : req0_srcA;
        ex_b  = (win == 1) ? req1_srcB : req0_srcB;
        ex_op = (win == 1) ? req1_oper : req0_oper;
        e.port = win;
        e.res  = alu_f(ex_op, ex_a, ex_b);
        e.zero = (e.res == 32'd0);
        e.due  = cyc + 2;
        sb.push_back(e);
        outstanding = 1;
        exec_cyc    = cyc + 1;
        last_grant  = win;
      end
    end
  end

  // ---------------- Monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    int   p;
    if (!rst) begin
      if (!rsp0_valid) begin
        chk("rsp0_result_idle", rsp0_result, 32'd0);
        chk("rsp0_zero_idle", 32'(rsp0_zero), 32'd0);
      end
      if (!rsp1_valid) begin
        chk("rsp1_result_idle", rsp1_result, 32'd0);
        chk("rsp1_zero_idle", 32'(rsp1_zero), 32'd0);
      end
      chk("rsp_valid_onehot", 32'(rsp0_valid && rsp1_valid), 32'd0);
      if (rsp0_valid || rsp1_valid) begin
        p = rsp1_valid ? 1 : 0;
        if (sb.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          e = sb[0];
          chk("rsp_port", 32'(p), 32'(e.port));
          chk("rsp_result", (p == 1) ? rsp1_result : rsp0_result, e.res);
          chk("rsp_zero", 32'((p == 1) ? rsp1_zero : rsp0_zero), 32'(e.zero));
          chk("rsp_not_early", 32'(cyc >= e.due), 32'd1);
          if ((p == 1) ? rsp1_ready : rsp0_ready) begin
            void'(sb.pop_front());
            outstanding = 0;
            idle_from   = cyc + 1;
          end
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        fail_now("rsp_missing");
        void'(sb.pop_front());
        outstanding = 0;
        idle_from   = cyc + 1;
      end
    end
    if (cyc == exec_cyc) begin
      chk("alu_srcA_exec", alu_srcA, ex_a);
      chk("alu_srcB_exec", alu_srcB, ex_b);
      chk("alu_oper_exec", 32'(alu_oper), 32'(ex_op));
    end else begin
      chk("alu_srcA_idle", alu_srcA, 32'd0);
      chk("alu_srcB_idle", alu_srcB, 32'd0);
      chk("alu_oper_idle", 32'(alu_oper), 32'(`ALU_ADD));
    end
  end

  // ---------------- Stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rand_op();
    case ($urandom_range(4))
      0:       return `ALU_ADD;
      1:       return `ALU_OR;
      2:       return `ALU_SRL;
      3:       return `ALU_SLTU;
      default: return `ALU_SUB;
    endcase
  endfunction

  task automatic set_req(input int p, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      req0_valid = v; req0_oper = op; req0_srcA = a; req0_srcB = b;
    end else begin
      req1_valid = v; req1_oper = op; req1_srcA = a; req1_srcB = b;
    end
  endtask

  task automatic set_rand_req(input int p);
    logic [31:0] a;
    a = $urandom();
    set_req(p, 1'b1, rand_op(), a, ($urandom_range(3) == 0) ? a : 32'($urandom()));
  endtask

  // Returns in the cycle after the accepting edge, with the port's valid dropped.
  task automatic wait_accept(input int p);
    bit done = 1'b0;
    int n    = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
      if ((p == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) done = 1'b1;
    end
    if (!done) fail_now("accept_timeout");
    tick();
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic do_op(input int p, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] want, input string name);
    bit seen = 1'b0;
    int n    = 0;
    set_req(p, 1'b1, op, a, b);
    wait_accept(p);
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      if ((p == 0) ? rsp0_valid : rsp1_valid) seen = 1'b1;
    end
    if (!seen) fail_now(name);
    else chk(name, (p == 0) ? rsp0_result : rsp1_result, want);
    tick();
  endtask

  initial begin
    int got[$];
    int exp_g[4];
    int n;
    bit a0, a1, hold0, hold1;

    rst = 1'b1;
    set_req(0, 1'b0, `ALU_ADD, 32'd0, 32'd0);
    set_req(1, 1'b0, `ALU_ADD, 32'd0, 32'd0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    do_reset();

    // Reset state.
    @(negedge clk);
    chk("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("reset_rsp0_result", rsp0_result, 32'd0);
    tick();

    // Single op: 5 + 7 on port 0, valid exactly in N+2.
    set_req(0, 1'b1, `ALU_ADD, 32'd5, 32'd7);
    wait_accept(0);
    @(negedge clk);
    chk("single_valid_n1", 32'(rsp0_valid), 32'd0);
    @(negedge clk);
    chk("single_valid_n2", 32'(rsp0_valid), 32'd1);
    chk("single_result", rsp0_result, 32'd12);
    chk("single_zero", 32'(rsp0_zero), 32'd0);
    @(negedge clk);
    chk("single_valid_n3", 32'(rsp0_valid), 32'd0);
    tick();

    // Back-pressure: SUB 9,9 on port 1 held for 5 cycles while port 0 waits.
    rsp1_ready = 1'b0;
    set_req(1, 1'b1, `ALU_SUB, 32'd9, 32'd9);
    wait_accept(1);
    set_req(0, 1'b1, `ALU_ADD, 32'd3, 32'd4);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp1_valid), 32'd1);
      chk("bp_result", rsp1_result, 32'd0);
      chk("bp_zero", 32'(rsp1_zero), 32'd1);
      chk("bp_req0_ready", 32'(req0_ready), 32'd0);
    end
    tick();
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp1_valid), 32'd1);
    wait_accept(0);
    repeat (3) tick();

    // Contention from a fresh reset: both ports valid for four operations.
    do_reset();
    set_rand_req(0);
    set_rand_req(1);
    n = 0;
    while (got.size() < 4 && n < 60) begin
      @(negedge clk);
      n++;
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0) got.push_back(0);
      if (a1) got.push_back(1);
      tick();
      if (a0) set_rand_req(0);
      if (a1) set_rand_req(1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (RrEn) exp_g = '{0, 1, 0, 1};
    else      exp_g = '{0, 0, 0, 0};
    chk("contention_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) chk("contention_grant", 32'(got[i]), 32'(exp_g[i]));
    repeat (4) tick();

    // Opcode sweep, each on a specific port.
    do_op(1, `ALU_OR,   32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, "sweep_or");
    do_op(0, `ALU_SRL,  32'h8000_0000, 32'd31,        32'd1,         "sweep_srl");
    do_op(1, `ALU_SLTU, 32'd1,         32'd2,         32'd1,         "sweep_sltu");

    // Reset during EXEC: no response, pointer reloaded.
    set_req(1, 1'b1, `ALU_ADD, 32'd1, 32'd2);
    wait_accept(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("rstmid_rsp1_valid", 32'(rsp1_valid), 32'd0);
    end
    tick();
    set_rand_req(0);
    set_rand_req(1);
    @(negedge clk);
    chk("rstmid_grant0", 32'(req0_ready), 32'd1);
    chk("rstmid_grant1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) tick();

    // Random traffic with random response back-pressure and request withdrawal.
    hold0 = 1'b0;
    hold1 = 1'b0;
    a0    = 1'b0;
    a1    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (a0) begin hold0 = 1'b0; req0_valid = 1'b0; end
      if (a1) begin hold1 = 1'b0; req1_valid = 1'b0; end
      if (hold0 && $urandom_range(7) == 0) begin hold0 = 1'b0; req0_valid = 1'b0; end
      if (!hold0 && $urandom_range(2) == 0) begin hold0 = 1'b1; set_rand_req(0); end
      if (!hold1 && $urandom_range(2) == 0) begin hold1 = 1'b1; set_rand_req(1); end
      rsp0_ready = ($urandom_range(3) != 0);
      rsp1_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
    end

    // Drain.
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_alu_arb.md
# sr_alu_arb

Two-port arbiter and sequencer that shares a single `sr_alu` instance between two requesters: port 0, the CPU execute path, and port 1, a debug/accelerator path. It accepts one operation at a time through a valid/ready handshake, registers the operands, drives the shared ALU for one cycle and captures the result. The result is then held on the granted port's response channel until that port accepts it. The block sits between the requesters and `sr_alu`, and it uses the `ALU_*` opcode macros from `sr_cpu.vh`.

## Interface
Parameters:
- none; the data width is fixed at 32 and the opcode width at 3.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req0_valid`, `req1_valid`  in  1  request present on port 0 / port 1.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_srcA`, `req0_srcB`, `req1_srcA`, `req1_srcB`  in  32  operands.
- `req0_oper`, `req1_oper`  in  3  ALU opcode (`ALU_*`).
- `rsp0_valid`, `rsp1_valid`  out  1  result available.
- `rsp0_ready`, `rsp1_ready`  in  1  requester consumes the result.
- `rsp0_result`, `rsp1_result`  out  32  registered ALU result.
- `rsp0_zero`, `rsp1_zero`  out  1  registered ALU zero flag.
- `alu_srcA`, `alu_srcB`  out  32  operands driven to the shared ALU.
- `alu_oper`  out  3  opcode driven to the shared ALU.
- `alu_result`  in  32  result from the ALU (combinational).
- `alu_zero`  in  1  zero flag from the ALU.

## Operation
State machine states:
- IDLE
  - Arbitrate between `req0_valid` and `req1_valid`.
  - Assert `reqN_ready` only for the winner, and only while that port's `reqN_valid` is high.
  - On accept, latch srcA, srcB, oper and the grant index, then go to EXEC.
- EXEC
  - Drive `alu_*` from the latched operands.
  - At the clock edge, capture `alu_result` and `alu_zero` into the response register, then go to RESP.
- RESP
  - Assert `rspG_valid` for the granted port G only.
  - While `rspG_ready` is 0, hold the result and flag unchanged.
  - When `rspG_ready` is 1, go to IDLE.

General rules:
- `reqN_ready` is low in EXEC and RESP. At most one `reqN_ready` is high in any cycle.
- The response outputs of the non-granted port are 0.
- `rspN_result` and `rspN_zero` are 0 whenever `rspN_valid` is 0.
- Outside EXEC, `alu_srcA` = 0, `alu_srcB` = 0 and `alu_oper` = `ALU_ADD`.
- The block never modifies operands. Width and arithmetic rules belong to the ALU.
- The arbitration policy is set under Configuration.

## Timing
- Accept at edge N (IDLE, valid && ready).
- `alu_*` are driven during cycle N+1.
- `rspG_valid` rises after edge N+1 and is high from cycle N+2.
- Minimum occupancy is 3 cycles per operation; peak throughput is one operation per 3 cycles.
- If `rspG_ready` is already high in cycle N+2, the block is back in IDLE at cycle N+3 and can accept a new request there.
- Response back-pressure stalls the block indefinitely. Both requesters then see ready = 0.

Reset values:
- State = IDLE.
- All ready and valid outputs = 0.
- Response registers = 0.
- `alu_*` = idle values.
- Round-robin pointer = "last grant was port 1", so port 0 wins first.

Reset mid-operation:
- An asserted `rst` in EXEC or RESP discards the operation; no response is produced.
- It returns the block to IDLE and reloads the pointer.

Simultaneous events:
- A request held valid during EXEC or RESP is not accepted. It is arbitrated again at the next IDLE.
- Dropping `reqN_valid` before it is accepted is legal.

## Configuration
- `SR_ALU_ARB_RR_EN` defined: round-robin arbitration.
  - When both ports are valid in IDLE, grant the port not granted last.
  - The pointer updates only on accept.
  - A single valid port always wins.
- `SR_ALU_ARB_RR_EN` not defined: fixed priority, port 0 always wins. The pointer register is not built.

## Test plan
- Single op: port 0 requests srcA = 5, srcB = 7, `ALU_ADD`, with `rsp0_ready` = 1.
  - `rsp0_valid` is high in cycle N+2 only.
  - `rsp0_result` = 12, `rsp0_zero` = 0.
  - Block is back in IDLE at N+3.
- Back-pressure: port 1 requests `ALU_SUB` 9, 9 with `rsp1_ready` held at 0 for 5 cycles.
  - Result 0 and zero = 1 stay stable.
  - `req0_ready` stays 0 throughout, even with `req0_valid` = 1.
  - The result is released on the first cycle `rsp1_ready` = 1.
- Contention: both ports hold valid for 4 operations.
  - With `SR_ALU_ARB_RR_EN`: grants are 0, 1, 0, 1.
  - Without it: grants are 0, 0, 0, 0, and port 1 starves.
- Opcode sweep: `ALU_OR` 0xF0 | 0x0F gives 0xFF.
  - `ALU_SRL` 0x80000000 by 31 gives 1.
  - `ALU_SLTU` 1 < 2 gives 1.
  - Each result is returned on the correct port.
- Reset mid-op: assert `rst` during EXEC.
  - The next cycle is IDLE with all valid outputs 0.
  - No response is emitted.
  - The next contended grant goes to port 0.
- Idle ALU drive: with no requests, `alu_srcA` = 0, `alu_srcB` = 0 and `alu_oper` = `ALU_ADD` in every cycle.
